// File: rtl/uart_transmitter.sv
// 8N1-style UART transmitter with a one-entry holding register so frames can run back-to-back.
// Bit period is OVERSAMPLE+1 clocks to line up with the receiver's mid-bit sampling cadence.
module uart_transmitter #(
  parameter int UART_BITS_TRANSFERED = 8,
  parameter int OVERSAMPLE           = 16,
  parameter int STOP_BITS            = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [UART_BITS_TRANSFERED-1:0] data_in,
  input  logic                            valid_in,
  output logic                            ready,
  output logic                            tx,
  output logic                            busy,
  output logic [1:0]                      o_dbg_state
);

  localparam int BIT_CYCLES  = OVERSAMPLE + 1;
  localparam int STOP_CYCLES = STOP_BITS * BIT_CYCLES;
  localparam int CNT_W       = $clog2(STOP_CYCLES);
  localparam int IDX_W       = (UART_BITS_TRANSFERED > 1) ? $clog2(UART_BITS_TRANSFERED) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_BITS_TRANSFERED - 1);

  // Handshake: a byte is taken on the rising edge where valid_in && ready; ready is
  // simply "holding register empty", so it never drops without an accept and valid_in
  // is ignored while it is low.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                          r_state;
  logic [UART_BITS_TRANSFERED-1:0] r_hold_data;
  logic                            r_hold_full;
  logic [UART_BITS_TRANSFERED-1:0] r_shift;
  logic [IDX_W-1:0]                r_bit_idx;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_tx;

  state_t                          w_state_nx;
  logic [UART_BITS_TRANSFERED-1:0] w_shift_nx;
  logic [UART_BITS_TRANSFERED-1:0] w_shift_sh;
  logic [IDX_W-1:0]                w_idx_nx;
  logic [CNT_W-1:0]                w_cnt_nx;
  logic                            w_tx_nx;
  logic                            w_load;
  logic                            w_accept;
  logic                            w_hold_full_nx;
  logic                            w_cnt_zero;

  assign w_accept   = valid_in && !r_hold_full;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_shift_sh = r_shift >> 1;

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_idx_nx   = r_bit_idx;
    w_cnt_nx   = r_cnt;
    w_tx_nx    = r_tx;
    w_load     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (r_hold_full) begin
          w_load = 1'b1;
        end
      end
      S_START: begin
        if (w_cnt_zero) begin
          w_state_nx = S_DATA;
          w_idx_nx   = '0;
          w_cnt_nx   = BIT_LAST;
          w_tx_nx    = r_shift[0];
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_cnt_zero) begin
          if (r_bit_idx == IDX_LAST) begin
            w_state_nx = S_STOP;
            w_cnt_nx   = STOP_LAST;
            w_tx_nx    = 1'b1;
          end else begin
            w_shift_nx = w_shift_sh;
            w_idx_nx   = r_bit_idx + IDX_W'(1);
            w_cnt_nx   = BIT_LAST;
            w_tx_nx    = w_shift_sh[0];
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_cnt_zero) begin
          if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
            w_tx_nx    = 1'b1;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase

    // A load from IDLE or from the end of STOP drives the start bit on the same edge.
    if (w_load) begin
      w_state_nx = S_START;
      w_shift_nx = r_hold_data;
      w_idx_nx   = '0;
      w_cnt_nx   = BIT_LAST;
      w_tx_nx    = 1'b0;
    end
  end

  // Accept and load never coincide: accept needs an empty holder, load needs a full one.
  assign w_hold_full_nx = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_cnt       <= '0;
      r_tx        <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_hold_full <= w_hold_full_nx;
      r_shift     <= w_shift_nx;
      r_bit_idx   <= w_idx_nx;
      r_cnt       <= w_cnt_nx;
      r_tx        <= w_tx_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_data <= data_in;
    end
  end

  assign ready       = !r_hold_full;
  assign tx          = r_tx;
  assign busy        = (r_state != S_IDLE) || r_hold_full;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: frame tables, back-to-back, mid-frame reset,
// a serial decoder scoreboard for loopback traffic, and a 2-stop-bit/short-period instance.
module tb_uart_transmitter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults ----------------
  logic [7:0] data_in_a;
  logic       valid_in_a;
  logic       ready_a, tx_a, busy_a;
  logic [1:0] dbg_a;

  uart_transmitter dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in_a),
    .valid_in   (valid_in_a),
    .ready      (ready_a),
    .tx         (tx_a),
    .busy       (busy_a),
    .o_dbg_state(dbg_a)
  );

  // ---------------- DUT B: OVERSAMPLE=4, STOP_BITS=2 ----------------
  logic [7:0] data_in_b;
  logic       valid_in_b;
  logic       ready_b, tx_b, busy_b;
  logic [1:0] dbg_b;

  uart_transmitter #(
    .UART_BITS_TRANSFERED(8),
    .OVERSAMPLE          (4),
    .STOP_BITS           (2)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in_b),
    .valid_in   (valid_in_b),
    .ready      (ready_b),
    .tx         (tx_b),
    .busy       (busy_b),
    .o_dbg_state(dbg_b)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  int         frames_seen = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits in time order: [0]=start, [8:1]=data LSB first, [9]=stop
  } vec_t;

  vec_t vecs[6];

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ready_a : ready_b;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the negedge right after the accepting edge (cycle k).
  task automatic send(input int sel, input logic [7:0] d, input bit push);
    int waited;
    waited = 0;
    @(negedge clk);
    if (sel == 0) begin data_in_a = d; valid_in_a = 1'b1; end
    else          begin data_in_b = d; valid_in_b = 1'b1; end
    while (!get_ready(sel) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!get_ready(sel)) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: ready still %0b after %0d cycles, expected 1", get_ready(sel), waited);
    end else if (push) begin
      exp_q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    if (sel == 0) valid_in_a = 1'b0;
    else          valid_in_b = 1'b0;
  endtask

  // Called at cycle k; checks every cycle of the frame, then the busy fall one cycle later.
  task automatic check_frame(input int sel, input logic [9:0] exp, input int os, input int sb,
                             input string name);
    int len;
    int bad;
    for (int b = 0; b < 10; b++) begin
      len = (b == 9) ? sb * (os + 1) : (os + 1);
      bad = 0;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if (get_tx(sel) !== exp[b]) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_errors++;
        $display("FAIL %s_bit%0d: tx wrong on %0d of %0d cycles, expected %0b", name, b, bad, len, exp[b]);
      end
    end
    check({name, "_busy_last"}, 32'(get_busy(sel)), 32'd1);
    @(negedge clk);
    check({name, "_busy_fall"}, 32'(get_busy(sel)), 32'd0);
    check({name, "_tx_idle"}, 32'(get_tx(sel)), 32'd1);
    check({name, "_ready_idle"}, 32'(get_ready(sel)), 32'd1);
  endtask

  task automatic wait_idle(input int sel, input int budget, input string name);
    int n;
    n = 0;
    while (get_busy(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(get_busy(sel)), 32'd0);
  endtask

  // ---------------- serial decoder (scoreboard consumer) ----------------
  initial begin
    logic [7:0] got;
    logic       start_bit;
    logic       stop_bit;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (mon_en && tx_a == 1'b0) begin
        repeat (8) @(negedge clk);
        start_bit = tx_a;
        for (int b = 0; b < 8; b++) begin
          repeat (17) @(negedge clk);
          got[b] = tx_a;
        end
        repeat (17) @(negedge clk);
        stop_bit = tx_a;
        frames_seen++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL lb_unexpected: got byte %02h, expected no frame", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want || start_bit !== 1'b0 || stop_bit !== 1'b1) begin
            n_errors++;
            $display("FAIL lb_frame: got byte %02h start %0b stop %0b, expected %02h start 0 stop 1",
                     got, start_bit, stop_bit, want);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [19:0] p;
    int          tx_bad;
    int          rdy_bad;
    logic [7:0]  lb_bytes[$];

    vecs[0] = '{data: 8'hA5, frame: 10'h34A};
    vecs[1] = '{data: 8'h00, frame: 10'h200};
    vecs[2] = '{data: 8'hFF, frame: 10'h3FE};
    vecs[3] = '{data: 8'h55, frame: 10'h2AA};
    vecs[4] = '{data: 8'hAA, frame: 10'h354};
    vecs[5] = '{data: 8'h01, frame: 10'h202};

    data_in_a  = 8'h00;
    valid_in_a = 1'b0;
    data_in_b  = 8'h00;
    valid_in_b = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;

    // Reset values while clock and valid_in toggle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_in_a = i[0];
      data_in_a  = 8'($urandom_range(0, 255));
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
    end
    @(negedge clk);
    valid_in_a = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    check("post_rst_tx", 32'(tx_a), 32'd1);
    check("post_rst_ready", 32'(ready_a), 32'd1);
    check("post_rst_busy", 32'(busy_a), 32'd0);
    check("post_rst_state", 32'(dbg_a), 32'd0);

    // Single frames from the table.
    for (int v = 0; v < 6; v++) begin
      send(0, vecs[v].data, 1'b0);
      check_frame(0, vecs[v].frame, 16, 1, $sformatf("frame_%02h", vecs[v].data));
    end

    // Back-to-back: 0x00 then 0xFF, third byte 0x11 held off.
    p = {10'h3FE, 10'h200};
    @(negedge clk);
    data_in_a  = 8'h00;
    valid_in_a = 1'b1;
    check("b2b_ready_idle", 32'(ready_a), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_ready_k", 32'(ready_a), 32'd0);
    data_in_a = 8'hFF;
    tx_bad  = 0;
    rdy_bad = 0;
    for (int i = 0; i < 340; i++) begin
      @(negedge clk);
      if (tx_a !== p[i / 17]) tx_bad++;
      if (i == 0) check("b2b_ready_k1", 32'(ready_a), 32'd1);
      if (i == 1) data_in_a = 8'h11;
      if (i >= 1 && i <= 169 && ready_a !== 1'b0) rdy_bad++;
      if (i == 169) check("b2b_last_stop", 32'(tx_a), 32'd1);
      if (i == 170) begin
        check("b2b_no_gap", 32'(tx_a), 32'd0);
        check("b2b_third_ready", 32'(ready_a), 32'd1);
      end
      if (i == 171) begin
        check("b2b_third_taken", 32'(ready_a), 32'd0);
        valid_in_a = 1'b0;
      end
    end
    check("b2b_tx_mismatch_cycles", 32'(tx_bad), 32'd0);
    check("b2b_ready_held_low_bad", 32'(rdy_bad), 32'd0);
    wait_idle(0, 400, "b2b_idle");

    // Reset during DATA bit 3 with a byte queued.
    send(0, 8'hF0, 1'b0);
    @(negedge clk);
    check("mid_ready_k1", 32'(ready_a), 32'd1);
    data_in_a  = 8'h0F;
    valid_in_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in_a = 1'b0;
    check("mid_queued", 32'(ready_a), 32'd0);
    repeat (73) @(negedge clk);
    check("mid_in_data", 32'(dbg_a), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_a), 32'd1);
    check("mid_rst_ready", 32'(ready_a), 32'd1);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) tx_bad++;
    end
    check("mid_no_residual", 32'(tx_bad), 32'd0);
    send(0, 8'h3C, 1'b0);
    check_frame(0, 10'h278, 16, 1, "after_rst_3c");

    // Loopback through the decoder, continuously offered.
    lb_bytes = '{8'h00, 8'hFF, 8'h55, 8'hAA};
    for (int i = 0; i < 200; i++) lb_bytes.push_back(8'($urandom_range(0, 255)));
    @(negedge clk);
    mon_en = 1'b1;
    foreach (lb_bytes[i]) send(0, lb_bytes[i], 1'b1);
    wait_idle(0, 1000, "lb_idle");
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    check("lb_queue_empty", 32'(exp_q.size()), 32'd0);
    check("lb_frames_seen", 32'(frames_seen), 32'd204);

    // STOP_BITS=2, OVERSAMPLE=4 instance: 55-cycle frame.
    send(1, 8'h81, 1'b0);
    check_frame(1, 10'h302, 4, 2, "sb2_81");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8N1 UART transmitter (configurable data width and stop bits), the transmit-side partner of the existing UART receiver.
- Accepts parallel bytes over a valid/ready handshake and serialises them LSB-first on `tx`.
- Bit timing is sized so the team's receiver, clocked from the same `clk`, samples every bit at mid-bit.
- Has a one-entry holding register, so a second byte can be queued while a frame is on the line. Frames then go back-to-back with no idle gap.

Parameters:
- UART_BITS_TRANSFERED, 8: data bits per frame.
- OVERSAMPLE, 16: bit period is OVERSAMPLE+1 clk cycles, which matches the receiver's sample cadence. Legal values ≥ 2.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- data_in  input  UART_BITS_TRANSFERED  byte to send; sampled when valid_in && ready.
- valid_in  input  1  producer has data_in available.
- ready  output  1  holding register empty; byte accepted on the edge where valid_in && ready.
- tx  output  1  serial line, idle high; registered output.
- busy  output  1  high while a frame is on the line or the holding register is full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, ready=1, busy=0.
  - FSM goes to IDLE; holding register cleared; bit and cycle counters = 0.
  - Reset asserted mid-frame aborts the frame: tx goes to 1 immediately and the queued byte is discarded.
- Handshake:
  - ready = !hold_full.
  - Accept at edge k sets hold_full.
  - data_in may change freely when not accepted.
  - valid_in is ignored while ready=0. There is no overwrite, and ready never drops without an accept.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If hold_full: load the shift register from the holding register, clear hold_full, go to START, drive tx=0 (all at one edge).
  - Result: a byte accepted at edge k drives tx low at edge k+1, and ready is high again after edge k+1.
- START: hold tx=0 for OVERSAMPLE+1 cycles, then go to DATA with bit index 0.
- DATA:
  - Drive tx = shift[0] for OVERSAMPLE+1 cycles, then shift right and increment the bit index.
  - After bit UART_BITS_TRANSFERED-1, go to STOP.
- STOP:
  - Hold tx=1 for STOP_BITS*(OVERSAMPLE+1) cycles.
  - At the end, if hold_full: reload and go directly to START (tx=0 on that same edge, no idle cycle). Otherwise go to IDLE.
- Cycle counter runs OVERSAMPLE down to 0; the bit period ends on the count==0 cycle.
- Frame length = (1 + UART_BITS_TRANSFERED + STOP_BITS) * (OVERSAMPLE+1) cycles. Defaults give 170 cycles.
- A byte can be accepted at any time while ready=1, including during START/DATA/STOP of the current frame. The byte in flight is never altered.
- busy = (state != IDLE) || hold_full. It is combinational from registers and drops the cycle after the last stop period ends when nothing is queued.
- tx is a flop output, glitch-free, and changes only on bit boundaries.

Test Plan:
- Reset values: hold rst_n=0 and toggle clk/valid_in → tx=1, ready=1, busy=0 throughout. Release → values unchanged with valid_in=0.
- Single frame, defaults, data_in=0xA5 accepted at edge k:
  - tx=0 during cycles k+1..k+17.
  - Then 17 cycles each of the LSB-first bits 1,0,1,0,0,1,0,1.
  - Then 17 cycles of tx=1.
  - busy falls at k+171.
- Back-to-back: offer 0x00 then 0xFF continuously →
  - Second byte accepted at k+2, after which ready=0 until the second frame loads.
  - First stop bit is followed immediately by the second start bit (no tx=1 cycle beyond 17).
  - A third byte offered is held off (ready=0) until edge k+171.
- Loopback into the team's receiver (same clk, OVERSAMPLE=16) → receiver valid pulses once per frame with result equal to 0x00, 0xFF, 0x55, 0xAA and 200 random bytes, including with back-to-back frames.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 with a byte queued → tx=1 asynchronously, ready=1, busy=0. After release no residual frame is sent. A new byte 0x3C is transmitted correctly.
- STOP_BITS=2, OVERSAMPLE=4, byte 0x81 → start 5 cycles, bits 1,0,0,0,0,0,0,1 for 5 cycles each, stop high for 10 cycles. Frame length is 55 cycles.
